ibus_dbus_arbiter: RTL and testbench
====================================

Name: ibus_dbus_arbiter

Overview:
- Shares one memory port between the core's instruction bus (ibus) and data bus (dbus).
- Sits between `core` and the memory/AXI bridge; it replaces the dual-port zero-delay hookup once instruction and data memory are unified.
- Each transaction is granted to one requester and held to completion (address phase then data phase).
- Responses are routed only to the owner. Zero-latency memory (addr_ok and data_ok in the grant cycle) completes in one cycle.

Parameters:
- ADDR_W, 64, address width of requests and memory port
- DATA_W, 64, data width of memory port (ibus uses low 32 bits)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ireq  in  ibus_req_t  instruction request {valid, addr}
- iresp  out  ibus_resp_t  instruction response {addr_ok, data_ok, data[31:0]}
- dreq  in  dbus_req_t  data request {valid, addr, size, strobe, data}
- dresp  out  dbus_resp_t  data response {addr_ok, data_ok, data[63:0]}
- mreq_valid  out  1  memory request valid
- mreq_addr  out  ADDR_W  memory address
- mreq_size  out  3  access size (msize_t; ibus requests use MSIZE4)
- mreq_strobe  out  DATA_W/8  byte write strobe; 0 = read
- mreq_data  out  DATA_W  write data
- mresp_addr_ok  in  1  memory accepted address
- mresp_data_ok  in  1  memory returns data / write done
- mresp_data  in  DATA_W  read data

Behaviour:
- State machine (arb_state_t): IDLE, BUSY_ADDR, BUSY_DATA. Registers: state, owner (OWN_I/OWN_D), last_owner.
- Reset (reset==0, async): state=IDLE, owner=OWN_I, last_owner=OWN_I. All outputs are combinational from state, so during reset mreq_valid=0 and iresp/dresp are all-zero.
- IDLE, winner selection:
  - no valid requester -> mreq_valid=0.
  - only one valid -> that requester wins.
  - both valid -> dbus wins (see Optional Feature).
- IDLE, once a winner exists: drive mreq_* from the winner combinationally, mreq_valid=1. Then:
  - addr_ok & data_ok -> completes this cycle, stay IDLE.
  - addr_ok only -> BUSY_DATA.
  - neither -> BUSY_ADDR.
  - In the two non-completing cases, latch owner=winner.
- BUSY_ADDR: mreq_* driven from owner's live request, mreq_valid=1. Same three-way transition as IDLE.
- BUSY_DATA: mreq_valid=0, other mreq_* fields 0. data_ok -> IDLE.
- data_ok without prior or same-cycle addr_ok is ignored in IDLE/BUSY_ADDR.
- Response routing:
  - owner's resp.addr_ok = mresp_addr_ok while in address phase.
  - owner's resp.data_ok = mresp_data_ok in the completing cycle.
  - owner's resp.data = mresp_data (iresp.data = mresp_data[31:0]).
  - Non-owner response is all-zero every cycle.
- last_owner updates to the served requester on each completion (data_ok).
- Requesters hold valid and fields stable until data_ok. A drop mid-transaction is a protocol violation: the arbiter still finishes the transaction and discards the data.
- Back-to-back: the cycle after completion is IDLE and may grant a new winner immediately. No bubble beyond the memory's own latency.
- Reset mid-transaction aborts to IDLE. Memory side is reset by the same signal.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both are valid in IDLE, grant the requester != last_owner. Reset value OWN_I means dbus wins the first tie.
- Undefined: fixed priority, dbus always wins ties. last_owner is unused (may be optimised away).

Decomposition:
- common package:
  - arb_state_t (IDLE/BUSY_ADDR/BUSY_DATA)
  - owner_t (OWN_I/OWN_D)
  - reuse of existing ibus/dbus req/resp structs and msize_t
- One sub-module, arb_pick: combinational winner select (ivalid, dvalid, last_owner -> winner, any). It is the only place ARB_ROUND_ROBIN_EN is consulted.

Test Plan:
- Zero-delay memory (addr_ok=data_ok=1 always), ireq.valid=1 addr=0x8000_0000, dreq.valid=0 -> iresp.data_ok=1 same cycle, iresp.data=mresp_data[31:0]; state stays IDLE.
- Both valid, memory addr_ok at cycle 0, data_ok at cycle 2, data=0xDEAD_BEEF -> dbus granted; dresp.data_ok=1 at cycle 2 with 0xDEAD_BEEF; iresp all-zero throughout; ibus granted at cycle 3.
- Memory holds addr_ok=0 for 3 cycles -> mreq_valid=1 with stable addr in BUSY_ADDR; no response to either side until accepted.
- Both requesters continuously valid, 1-cycle memory:
  - ARB_ROUND_ROBIN_EN defined -> grants alternate D,I,D,I.
  - Undefined -> D every time.
- Write: dreq strobe=0xFF, data=0x1122_3344_5566_7788 -> mreq_strobe=0xFF, mreq_data matches, dresp.data_ok on memory data_ok.
- reset asserted low while in BUSY_DATA -> immediately mreq_valid=0, iresp/dresp zero; after release, a pending ireq is granted from IDLE.

Source files
------------

// File: rtl/ibus_dbus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory-port arbiter.
//   - ibus/dbus request and response structs, msize_t
//   - arb_state_t : IDLE / BUSY_ADDR / BUSY_DATA
//   - owner_t     : OWN_I / OWN_D
package ibus_dbus_arbiter_pkg;

    localparam int unsigned PKG_ADDR_W = 64;
    localparam int unsigned PKG_DATA_W = 64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic                  valid;
        logic [PKG_ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic                    valid;
        logic [PKG_ADDR_W-1:0]   addr;
        msize_t                  size;
        logic [PKG_DATA_W/8-1:0] strobe;
        logic [PKG_DATA_W-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic                  addr_ok;
        logic                  data_ok;
        logic [PKG_DATA_W-1:0] data;
    } dbus_resp_t;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE      = 2'd0;
    localparam arb_state_t BUSY_ADDR = 2'd1;
    localparam arb_state_t BUSY_DATA = 2'd2;

    typedef logic owner_t;
    localparam owner_t OWN_I = 1'b0;
    localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/ibus_dbus_arbiter_arb_pick.sv
// Combinational winner select between ibus and dbus.
// Ports:
//   i_ivalid, i_dvalid : requester valids
//   i_last_owner       : requester served by the last completed transaction
//   o_winner           : selected requester (meaningful only when o_any)
//   o_any              : at least one requester valid
// Macro ARB_ROUND_ROBIN_EN: ties go to the requester that was not served last;
// otherwise dbus always wins ties.
module arb_pick
    import ibus_dbus_arbiter_pkg::*;
(
    input  logic   i_ivalid,
    input  logic   i_dvalid,
    input  owner_t i_last_owner,
    output owner_t o_winner,
    output logic   o_any
);

    always_comb begin
        o_any    = i_ivalid | i_dvalid;
        o_winner = OWN_I;
        if (i_ivalid && i_dvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
            o_winner = (i_last_owner == OWN_I) ? OWN_D : OWN_I;
`else
            o_winner = OWN_D;
`endif
        end else if (i_dvalid) begin
            o_winner = OWN_D;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history.
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;
`endif

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// Shares one memory port between the instruction bus and the data bus.
// A granted transaction is held to completion (address phase, then data phase);
// responses go only to the owner. Zero-latency memory completes in the grant cycle.
// Ports:
//   clk, reset (async, active-low)
//   ireq/iresp, dreq/dresp : core-side request/response structs
//   mreq_*                 : memory request (valid, addr, size, strobe, data)
//   mresp_*                : memory response (addr_ok, data_ok, data)
// Macro ARB_ROUND_ROBIN_EN (consulted in arb_pick only) selects round-robin ties.
module ibus_dbus_arbiter
    import ibus_dbus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  ibus_req_t           ireq,
    output ibus_resp_t          iresp,
    input  dbus_req_t           dreq,
    output dbus_resp_t          dresp,
    output logic                mreq_valid,
    output logic [ADDR_W-1:0]   mreq_addr,
    output msize_t              mreq_size,
    output logic [DATA_W/8-1:0] mreq_strobe,
    output logic [DATA_W-1:0]   mreq_data,
    input  logic                mresp_addr_ok,
    input  logic                mresp_data_ok,
    input  logic [DATA_W-1:0]   mresp_data
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t r_state, w_state_nxt;
    owner_t     r_owner, w_owner_nxt;
    owner_t     r_last_owner, w_last_nxt;

    owner_t w_winner;
    owner_t w_sel;
    logic   w_any;
    logic   w_addr_phase;
    logic   w_data_phase;
    logic   w_complete;
    logic   w_sel_valid;

    arb_pick u_arb_pick (
        .i_ivalid     (ireq.valid),
        .i_dvalid     (dreq.valid),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    // Phases are gated by reset so that all outputs are quiet while it is held.
    always_comb begin
        w_sel        = (r_state == IDLE) ? w_winner : r_owner;
        w_addr_phase = reset && ((r_state == IDLE && w_any) || r_state == BUSY_ADDR);
        w_data_phase = reset && (r_state == BUSY_DATA);
        w_complete   = (w_addr_phase && mresp_addr_ok && mresp_data_ok) ||
                       (w_data_phase && mresp_data_ok);
        w_sel_valid  = (w_sel == OWN_D) ? dreq.valid : ireq.valid;
    end

    always_comb begin
        mreq_valid  = 1'b0;
        mreq_addr   = '0;
        mreq_size   = MSIZE1;
        mreq_strobe = '0;
        mreq_data   = '0;
        if (w_addr_phase) begin
            mreq_valid = 1'b1;
            if (w_sel == OWN_D) begin
                mreq_addr   = ADDR_W'(dreq.addr);
                mreq_size   = dreq.size;
                mreq_strobe = STRB_W'(dreq.strobe);
                mreq_data   = DATA_W'(dreq.data);
            end else begin
                mreq_addr = ADDR_W'(ireq.addr);
                mreq_size = MSIZE4;
            end
        end
    end

    // A requester that dropped valid mid-transaction gets nothing back.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (w_sel_valid) begin
            if (w_sel == OWN_D) begin
                dresp.addr_ok = w_addr_phase & mresp_addr_ok;
                dresp.data_ok = w_complete;
                dresp.data    = w_complete ? PKG_DATA_W'(mresp_data) : '0;
            end else begin
                iresp.addr_ok = w_addr_phase & mresp_addr_ok;
                iresp.data_ok = w_complete;
                iresp.data    = w_complete ? mresp_data[31:0] : '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        case (r_state)
            IDLE, BUSY_ADDR: begin
                if (w_addr_phase) begin
                    if (mresp_addr_ok && mresp_data_ok) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = w_sel;
                    end else if (mresp_addr_ok) begin
                        w_state_nxt = BUSY_DATA;
                        w_owner_nxt = w_sel;
                    end else begin
                        w_state_nxt = BUSY_ADDR;
                        w_owner_nxt = w_sel;
                    end
                end
            end
            BUSY_DATA: begin
                if (mresp_data_ok) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_I;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
module tb_ibus_dbus_arbiter;
    import ibus_dbus_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic        mreq_valid;
    logic [63:0] mreq_addr;
    msize_t      mreq_size;
    logic [7:0]  mreq_strobe;
    logic [63:0] mreq_data;
    logic        mresp_addr_ok;
    logic        mresp_data_ok;
    logic [63:0] mresp_data;

    int n_pass  = 0;
    int n_total = 0;

    ibus_dbus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq          (ireq),
        .iresp         (iresp),
        .dreq          (dreq),
        .dresp         (dresp),
        .mreq_valid    (mreq_valid),
        .mreq_addr     (mreq_addr),
        .mreq_size     (mreq_size),
        .mreq_strobe   (mreq_strobe),
        .mreq_data     (mreq_data),
        .mresp_addr_ok (mresp_addr_ok),
        .mresp_data_ok (mresp_data_ok),
        .mresp_data    (mresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change just after the falling edge; checks follow 1ns later.
    task automatic mem(input logic a, input logic d, input logic [63:0] data);
        mresp_addr_ok = a;
        mresp_data_ok = d;
        mresp_data    = data;
    endtask

    initial begin
        logic exp_d;
        reset = 1'b0;
        ireq  = '0;
        dreq  = '0;
        mem(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0000;

        // Reset holds everything quiet even with a pending request.
        @(negedge clk); #1;
        chk("rst_mreq_valid", mreq_valid, 0);
        chk("rst_iresp", iresp, 0);
        chk("rst_dresp", dresp, 0);

        // Zero-latency memory, ibus alone.
        @(negedge clk);
        reset = 1'b1;
        mem(1'b1, 1'b1, 64'hCAFE_F00D_1234_5678);
        #1;
        chk("zl_mreq_valid", mreq_valid, 1);
        chk("zl_mreq_addr", mreq_addr, 64'h8000_0000);
        chk("zl_mreq_size", mreq_size, MSIZE4);
        chk("zl_mreq_strobe", mreq_strobe, 0);
        chk("zl_iresp_data_ok", iresp.data_ok, 1);
        chk("zl_iresp_data", iresp.data, 32'h1234_5678);
        chk("zl_dresp", dresp, 0);
        @(negedge clk);
        chk("zl_state_idle", dut.r_state, IDLE);

        // Both valid: dbus wins, data two cycles after address accept.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h1000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        mem(1'b1, 1'b0, 64'h0);
        #1;
        chk("c0_mreq_addr", mreq_addr, 64'h1000);
        chk("c0_dresp_addr_ok", dresp.addr_ok, 1);
        chk("c0_dresp_data_ok", dresp.data_ok, 0);
        chk("c0_iresp", iresp, 0);
        @(negedge clk);
        mem(1'b0, 1'b0, 64'h0);
        #1;
        chk("c1_mreq_valid", mreq_valid, 0);
        chk("c1_mreq_addr", mreq_addr, 0);
        chk("c1_dresp", dresp, 0);
        chk("c1_iresp", iresp, 0);
        @(negedge clk);
        mem(1'b0, 1'b1, 64'hDEAD_BEEF);
        #1;
        chk("c2_dresp_data_ok", dresp.data_ok, 1);
        chk("c2_dresp_data", dresp.data, 64'hDEAD_BEEF);
        chk("c2_iresp", iresp, 0);
        @(negedge clk);
        dreq.valid = 1'b0;
        mem(1'b1, 1'b1, 64'h0000_0000_ABCD_0123);
        #1;
        chk("c3_mreq_addr", mreq_addr, 64'h8000_0000);
        chk("c3_iresp_data_ok", iresp.data_ok, 1);
        chk("c3_iresp_data", iresp.data, 32'hABCD_0123);

        // Address stall for 3 cycles; stray data_ok in the middle is ignored.
        @(negedge clk);
        ireq.valid = 1'b0;
        dreq.valid = 1'b1;
        dreq.addr  = 64'h2000;
        for (int k = 0; k < 3; k++) begin
            mem(1'b0, (k == 1), 64'h55);
            #1;
            chk($sformatf("st%0d_mreq_valid", k), mreq_valid, 1);
            chk($sformatf("st%0d_mreq_addr", k), mreq_addr, 64'h2000);
            chk($sformatf("st%0d_dresp", k), dresp, 0);
            chk($sformatf("st%0d_iresp", k), iresp, 0);
            @(negedge clk);
        end
        mem(1'b1, 1'b1, 64'h55);
        #1;
        chk("st3_dresp_data_ok", dresp.data_ok, 1);
        chk("st3_dresp_data", dresp.data, 64'h55);

        // Reset pulse, then both continuously valid against zero-latency memory.
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset      = 1'b1;
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0000;
        dreq.valid = 1'b1;
        dreq.addr  = 64'h3000;
        mem(1'b1, 1'b1, 64'h77);
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            chk($sformatf("rr%0d_mreq_addr", k), mreq_addr,
                exp_d ? 64'h3000 : 64'h8000_0000);
            chk($sformatf("rr%0d_dresp_data_ok", k), dresp.data_ok, exp_d);
            chk($sformatf("rr%0d_iresp_data_ok", k), iresp.data_ok, !exp_d);
            @(negedge clk);
        end

        // dbus write.
        ireq.valid  = 1'b0;
        dreq.addr   = 64'h4000;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h1122_3344_5566_7788;
        mem(1'b1, 1'b0, 64'h0);
        #1;
        chk("wr_mreq_strobe", mreq_strobe, 8'hFF);
        chk("wr_mreq_data", mreq_data, 64'h1122_3344_5566_7788);
        chk("wr_mreq_size", mreq_size, MSIZE8);
        chk("wr_dresp_addr_ok", dresp.addr_ok, 1);
        chk("wr_dresp_data_ok0", dresp.data_ok, 0);
        @(negedge clk);
        mem(1'b0, 1'b1, 64'h0);
        #1;
        chk("wr_dresp_data_ok1", dresp.data_ok, 1);
        chk("wr_mreq_valid", mreq_valid, 0);

        // Reset while in BUSY_DATA aborts; pending ibus granted afterwards.
        @(negedge clk);
        dreq       = '0;
        ireq.valid = 1'b1;
        mem(1'b1, 1'b0, 64'h0);
        #1;
        chk("ra_iresp_addr_ok", iresp.addr_ok, 1);
        @(negedge clk);
        mem(1'b0, 1'b0, 64'h0);
        #1;
        chk("ra_state_busy_data", dut.r_state, BUSY_DATA);
        reset = 1'b0;
        #1;
        chk("ra_mreq_valid", mreq_valid, 0);
        chk("ra_iresp", iresp, 0);
        chk("ra_dresp", dresp, 0);
        chk("ra_state_idle", dut.r_state, IDLE);
        @(negedge clk);
        reset = 1'b1;
        mem(1'b1, 1'b1, 64'h0000_0000_0BAD_F00D);
        #1;
        chk("ra_regrant_valid", mreq_valid, 1);
        chk("ra_regrant_addr", mreq_addr, 64'h8000_0000);
        chk("ra_regrant_data_ok", iresp.data_ok, 1);
        chk("ra_regrant_data", iresp.data, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
